// File: rtl/dcpu_bus_pkg.sv
// Shared types and register map for the dcpu bus responder and its interval timer.
package dcpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_t;

  // Word offsets inside the 4-word I/O window
  localparam logic [1:0] REG_RELOAD = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;

endpackage

// File: rtl/dcpu_timer.sv
// Down-counting interval timer: reload/count/ctrl/pending registers, a read mux and a level irq.
module dcpu_timer
  import dcpu_bus_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [1:0]   wr_reg,
  input  logic [W-1:0] wr_dat,
  input  logic [1:0]   rd_reg,
  output logic [W-1:0] rd_dat,
  output logic         irq
);

  logic [W-1:0] reload;
  logic [W-1:0] count;
  logic         en;
  logic         irq_en;
  logic         pending;
  logic         expire;

  assign expire = en && (count == '0);
  assign irq    = pending & irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      reload  <= '0;
      count   <= '0;
      en      <= 1'b0;
      irq_en  <= 1'b0;
      pending <= 1'b0;
    end else begin
      // A RELOAD write takes priority over both decrement and expiry reload
      if (wr_en && (wr_reg == REG_RELOAD)) begin
        reload <= wr_dat;
        count  <= wr_dat;
      end else if (expire) begin
        count <= reload;
      end else if (en) begin
        count <= count - W'(1);
      end

      if (wr_en && (wr_reg == REG_CTRL)) begin
        en     <= wr_dat[CTRL_EN];
        irq_en <= wr_dat[CTRL_IRQEN];
      end

      // Expiry beats a simultaneous write-one-to-clear
      if (expire) begin
        pending <= 1'b1;
      end else if (wr_en && (wr_reg == REG_STATUS) && wr_dat[0]) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    case (rd_reg)
      REG_RELOAD: rd_dat = reload;
      REG_COUNT:  rd_dat = count;
      REG_CTRL: begin
        rd_dat[CTRL_EN]    = en;
        rd_dat[CTRL_IRQEN] = irq_en;
      end
      REG_STATUS: rd_dat[0] = pending;
      default:    rd_dat = '0;
    endcase
  end

endmodule

// File: rtl/dcpu_bus_responder.sv
// Responder end of the dcpu memory bus: RAM plus a timer I/O window behind a wait-state FSM.
// Handshake: i_cs is held with stable i_we/i_addr until o_ack pulses for one cycle; o_dat is valid only then.
module dcpu_bus_responder
  import dcpu_bus_pkg::*;
#(
  parameter int           W       = 16,
  parameter int           AW      = 12,
  parameter int           WAIT    = 0,
  parameter logic [W-1:0] IO_BASE = 16'hFFF0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cs,
  input  logic         i_we,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_ack,
  output logic         o_irq,
  output bus_state_t   dbg_state
);

  localparam logic [3:0] WAIT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  bus_state_t   state;
  logic [3:0]   wait_cnt;
  logic [W-1:0] lat_addr;
  logic [W-1:0] lat_dat;
  logic         lat_we;
  logic [W-1:0] mem [2**AW];

  logic [W-1:0] rd_addr;
  logic         rd_we;
  logic         go_ack;
  logic         commit;
  logic [W-1:0] rd_val;
  logic [W-1:0] tmr_rd;

  function automatic logic in_ram(input logic [W-1:0] a);
    return (a >> AW) == '0;
  endfunction

  function automatic logic in_io(input logic [W-1:0] a);
    return a[W-1:2] == IO_BASE[W-1:2];
  endfunction

  assign dbg_state = state;

  // With zero wait states the read is issued straight from the bus, before the latch settles
  assign rd_addr = (state == ST_IDLE) ? i_addr : lat_addr;
  assign rd_we   = (state == ST_IDLE) ? i_we : lat_we;
  assign go_ack  = i_cs && (((state == ST_IDLE) && (WAIT == 0)) ||
                            ((state == ST_WAIT) && (wait_cnt == 4'd0)));
  assign commit  = (state == ST_ACK) && lat_we && !i_reset;

  always_comb begin
    rd_val = '0;
    if (in_ram(rd_addr)) begin
      rd_val = mem[rd_addr[AW-1:0]];
    end else if (in_io(rd_addr)) begin
      rd_val = tmr_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      o_ack    <= 1'b0;
      o_dat    <= '0;
      wait_cnt <= '0;
      lat_addr <= '0;
      lat_dat  <= '0;
      lat_we   <= 1'b0;
    end else begin
      o_ack <= go_ack;
      o_dat <= (go_ack && !rd_we) ? rd_val : '0;
      case (state)
        ST_IDLE: begin
          if (i_cs) begin
            lat_addr <= i_addr;
            lat_dat  <= i_dat;
            lat_we   <= i_we;
            if (WAIT == 0) begin
              state <= ST_ACK;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!i_cs) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (commit && in_ram(lat_addr)) begin
      mem[lat_addr[AW-1:0]] <= lat_dat;
    end
  end

  dcpu_timer #(.W(W)) u_timer (
    .clk    (i_clk),
    .reset  (i_reset),
    .wr_en  (commit && in_io(lat_addr)),
    .wr_reg (lat_addr[1:0]),
    .wr_dat (lat_dat),
    .rd_reg (rd_addr[1:0]),
    .rd_dat (tmr_rd),
    .irq    (o_irq)
  );

endmodule

// File: tb/tb_dcpu_bus_responder.sv
// Randomised bench for dcpu_bus_responder: WAIT=0 and WAIT=3 instances checked against a bus/RAM/timer model.
module tb_dcpu_bus_responder;
  import dcpu_bus_pkg::*;

  localparam logic [15:0] IO_RELOAD = 16'hFFF0;
  localparam logic [15:0] IO_COUNT  = 16'hFFF1;
  localparam logic [15:0] IO_CTRL   = 16'hFFF2;
  localparam logic [15:0] IO_STATUS = 16'hFFF3;
  localparam int          FULL      = 99;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        cs   [2];
  logic        we   [2];
  logic [15:0] addr [2];
  logic [15:0] wd   [2];
  logic [15:0] rdat [2];
  logic        ack  [2];
  logic        irq  [2];
  bus_state_t  st   [2];

  dcpu_bus_responder #(.WAIT(0)) dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_cs(cs[0]), .i_we(we[0]), .i_addr(addr[0]), .i_dat(wd[0]),
    .o_dat(rdat[0]), .o_ack(ack[0]), .o_irq(irq[0]), .dbg_state(st[0])
  );

  dcpu_bus_responder #(.WAIT(3)) dut3 (
    .i_clk(clk), .i_reset(rst[1]), .i_cs(cs[1]), .i_we(we[1]), .i_addr(addr[1]), .i_dat(wd[1]),
    .o_dat(rdat[1]), .o_ack(ack[1]), .o_irq(irq[1]), .dbg_state(st[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: RAM contents, timer registers, bus expectations
  logic [15:0] mem_m [int];
  logic [15:0] m_reload [2];
  logic [15:0] m_count  [2];
  logic        m_en     [2];
  logic        m_ie     [2];
  logic        m_pend   [2];
  logic        mw_v     [2];
  logic [15:0] mw_a     [2];
  logic [15:0] mw_d     [2];
  logic        exp_ack  [2];
  logic        exp_dchk [2];
  logic [15:0] exp_dat  [2];
  logic        mon_en = 1'b0;
  logic        fired;

  function automatic int key(input int u, input logic [15:0] a);
    return (u << 16) | int'(a);
  endfunction

  function automatic logic [15:0] model_read(input int u, input logic [15:0] a);
    if (a < 16'h1000) return mem_m.exists(key(u, a)) ? mem_m[key(u, a)] : 16'h0000;
    case (a)
      IO_RELOAD: return m_reload[u];
      IO_COUNT:  return m_count[u];
      IO_CTRL:   return {14'd0, m_ie[u], m_en[u]};
      IO_STATUS: return {15'd0, m_pend[u]};
      default:   return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst[u]) begin
        m_reload[u] = 16'd0; m_count[u] = 16'd0;
        m_en[u] = 1'b0; m_ie[u] = 1'b0; m_pend[u] = 1'b0;
      end else begin
        fired = m_en[u] && (m_count[u] == 16'd0);
        if (mw_v[u] && (mw_a[u] < 16'h1000)) mem_m[key(u, mw_a[u])] = mw_d[u];
        if (mw_v[u] && (mw_a[u] == IO_RELOAD)) begin
          m_reload[u] = mw_d[u];
          m_count[u]  = mw_d[u];
        end else if (fired) begin
          m_count[u] = m_reload[u];
        end else if (m_en[u]) begin
          m_count[u] = m_count[u] - 16'd1;
        end
        if (mw_v[u] && (mw_a[u] == IO_CTRL)) begin
          m_en[u] = mw_d[u][0];
          m_ie[u] = mw_d[u][1];
        end
        if (fired) m_pend[u] = 1'b1;
        else if (mw_v[u] && (mw_a[u] == IO_STATUS) && mw_d[u][0]) m_pend[u] = 1'b0;
      end
    end
  end

  // per-cycle scoreboard of ack, idle data and interrupt level
  always @(negedge clk) begin
    if (mon_en) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("ack_u%0d", u), ack[u], exp_ack[u]);
        if (!exp_ack[u]) check($sformatf("idle_dat_u%0d", u), rdat[u], 0);
        else if (exp_dchk[u]) check($sformatf("rd_dat_u%0d", u), rdat[u], exp_dat[u]);
        check($sformatf("irq_u%0d", u), irq[u], m_pend[u] && m_ie[u]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One access starting now (1 time unit after an edge); hold < latency aborts it.
  task automatic access(input int u, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int hold, input logic keep);
    int lat = (u == 0) ? 1 : 4;
    logic [15:0] ex = 16'h0000;
    cs[u] = 1'b1; we[u] = w; addr[u] = a; wd[u] = d;
    for (int k = 0; k <= lat; k++) begin
      if (k == hold) cs[u] = 1'b0;
      if (k == lat - 1) ex = model_read(u, a);
      if ((k == lat) && (hold >= lat)) begin
        exp_ack[u] = 1'b1; exp_dchk[u] = !w; exp_dat[u] = ex;
        mw_v[u] = w; mw_a[u] = a; mw_d[u] = d;
      end
      step();
      exp_ack[u] = 1'b0; exp_dchk[u] = 1'b0; mw_v[u] = 1'b0;
    end
    if (!keep) cs[u] = 1'b0;
  endtask

  initial begin
    int u, op, hold, tries;
    logic w;
    logic [15:0] a, d;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cs[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
      mw_v[i] = 1'b0; mw_a[i] = '0; mw_d[i] = '0;
      exp_ack[i] = 1'b0; exp_dchk[i] = 1'b0; exp_dat[i] = '0;
    end
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("reset_state", 32'(st[i]), 32'(ST_IDLE));
      check("reset_ack", ack[i], 0);
      check("reset_dat", rdat[i], 0);
      check("reset_irq", irq[i], 0);
    end
    step(); step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    // zero wait states: write then read back
    access(0, 1'b1, 16'h0010, 16'h1234, FULL, 1'b0);
    access(0, 1'b0, 16'h0010, 16'h0000, FULL, 1'b0);

    // three wait states: pre-seed, aborted write, then back-to-back reads
    access(1, 1'b1, 16'h0020, 16'h0000, FULL, 1'b0);
    step();
    access(1, 1'b1, 16'h0020, 16'hBEEF, 2, 1'b0);
    step(); step();
    access(1, 1'b0, 16'h0020, 16'h0000, FULL, 1'b1);
    access(1, 1'b0, 16'h0020, 16'h0000, FULL, 1'b0);

    // timer: reload 5, enable + irq_en; irq rises 6 cycles after enable takes effect
    access(0, 1'b1, IO_RELOAD, 16'd5, FULL, 1'b0);
    access(0, 1'b1, IO_CTRL, 16'd3, FULL, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("irq_expiry_c%0d", i), irq[0], (i == 6) ? 1 : 0);
    end
    access(0, 1'b1, IO_STATUS, 16'd1, FULL, 1'b0);

    // W1C commit lands on the expiry edge: set must win
    tries = 0;
    while ((m_count[0] != 16'd1) && (tries < 40)) begin
      step();
      tries++;
    end
    check("w1c_align_timeout", (tries < 40) ? 1 : 0, 1);
    access(0, 1'b1, IO_STATUS, 16'd1, FULL, 1'b0);
    check("w1c_vs_expire", irq[0], 1);
    access(0, 1'b0, 16'h8000, 16'h0000, FULL, 1'b0);
    access(0, 1'b1, 16'hFFF5, 16'hFFFF, FULL, 1'b0);
    access(0, 1'b0, IO_COUNT, 16'h0000, FULL, 1'b0);

    // reset during a WAIT-state write
    access(1, 1'b1, 16'h0030, 16'hA5A5, FULL, 1'b0);
    access(1, 1'b1, IO_RELOAD, 16'd2, FULL, 1'b0);
    access(1, 1'b1, IO_CTRL, 16'd3, FULL, 1'b0);
    repeat (6) step();
    check("irq_before_reset", irq[1], 1);
    cs[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0030; wd[1] = 16'h5A5A;
    step();
    check("in_wait", 32'(st[1]), 32'(ST_WAIT));
    rst[1] = 1'b1; cs[1] = 1'b0;
    step();
    check("reset_mid_state", 32'(st[1]), 32'(ST_IDLE));
    check("reset_mid_irq", irq[1], 0);
    rst[1] = 1'b0;
    step();
    access(1, 1'b0, 16'h0030, 16'h0000, FULL, 1'b0);

    // seed a small RAM pool, then random traffic on both instances
    for (int i = 0; i < 16; i++) begin
      access(0, 1'b1, 16'h0100 + 16'(i), 16'($urandom), FULL, 1'b0);
      access(1, 1'b1, 16'h0100 + 16'(i), 16'($urandom), FULL, 1'b0);
    end
    for (int n = 0; n < 80; n++) begin
      u = $urandom_range(0, 1);
      op = $urandom_range(0, 5);
      hold = FULL;
      d = 16'($urandom);
      w = 1'b0;
      a = 16'h0100 + 16'($urandom_range(0, 15));
      case (op)
        0: w = 1'b1;
        1: w = 1'b0;
        2: a = IO_RELOAD + 16'($urandom_range(0, 3));
        3: begin a = 16'($urandom_range(16'h1000, 16'hFFEF)); w = 1'($urandom_range(0, 1)); end
        4: begin
          w = 1'b1;
          case ($urandom_range(0, 2))
            0: begin a = IO_RELOAD; d = 16'($urandom_range(0, 7)); end
            1: begin a = IO_CTRL; d = 16'($urandom_range(0, 3)); end
            default: begin a = IO_STATUS; d = 16'd1; end
          endcase
        end
        default: begin w = 1'b1; if (u == 1) hold = $urandom_range(1, 3); end
      endcase
      access(u, w, a, d, hold, (hold == FULL) ? 1'($urandom_range(0, 1)) : 1'b0);
      cs[0] = 1'b0; cs[1] = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    step();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
